spi_slave_apb_burst_plug: RTL and testbench

Parametrised SPI-slave-to-APB bridge plug. Sits between the SPI slave receive/transmit buffers and an APB4 master port. Turns received words into APB writes and SPI read requests into APB read bursts. Adds over the previous plug:
- configurable byte-address stride;
- wrap or linear burst addressing;
- PSTRB/PSLVERR support;
- PREADY timeout abort;
- sticky error reporting and registered TX data.

---
 rtl/spi_slave_apb_burst_plug.sv | 266 ++++++++++++++++++++++++++
 tb/tb_spi_slave_apb_burst_plug.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_apb_burst_plug.sv
// -----------------------------------------------------------------------------
// spi_slave_apb_burst_plug
//
// Bridge between the SPI slave receive/transmit buffers and an APB4 master
// port. Each received SPI word becomes one APB write beat. A start_tx request
// becomes an APB read burst of len = max(wrap_length, 1) beats. Each read word
// is handed back to the SPI transmit side before the next beat is issued.
//
// Burst addressing:
//   - A burst starts at base_addr and advances by ADDR_STRIDE bytes per beat.
//   - At the end of a block of len beats:
//       wrap_en = 1 : the address returns to base_addr.
//       wrap_en = 0 : the address keeps counting, and base_addr moves up with
//                     it, so a repeated start_tx continues the linear stream.
//   - An error (PSLVERR, or PREADY timeout) rewinds to base_addr and sets the
//     sticky err_flag.
//
// Ports
//   pclk, presetn         APB clock, asynchronous active-low reset
//   psel/penable/pwrite   APB control (master side)
//   paddr/pwdata/pstrb    APB address, write data, byte strobes
//   prdata/pready/pslverr APB response
//   rxtx_addr(_valid)     burst base address load (honoured only when idle)
//   start_tx              pulse: start a read burst (needs cs low)
//   cs                    SPI chip select, active-low; high ends a read burst
//   rx_data/valid/ready   write word handshake from the SPI receive buffer
//   tx_data/valid/ready   read word handshake to the SPI transmit buffer
//   wrap_length           beats per block (0 behaves as 1)
//   wrap_en               1 = wrap to base after the block, 0 = linear
//   busy                  bridge is not idle
//   err_flag/err_clr      sticky error flag and its clear
// -----------------------------------------------------------------------------
module spi_slave_apb_burst_plug #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int ADDR_STRIDE    = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        pclk,
    input  logic                        presetn,
    output logic                        psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [APB_ADDR_WIDTH-1:0]   paddr,
    output logic [APB_DATA_WIDTH-1:0]   pwdata,
    output logic [APB_DATA_WIDTH/8-1:0] pstrb,
    input  logic [APB_DATA_WIDTH-1:0]   prdata,
    input  logic                        pready,
    input  logic                        pslverr,
    input  logic [APB_ADDR_WIDTH-1:0]   rxtx_addr,
    input  logic                        rxtx_addr_valid,
    input  logic                        start_tx,
    input  logic                        cs,
    input  logic [APB_DATA_WIDTH-1:0]   rx_data,
    input  logic                        rx_valid,
    output logic                        rx_ready,
    output logic [APB_DATA_WIDTH-1:0]   tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    input  logic [15:0]                 wrap_length,
    input  logic                        wrap_en,
    output logic                        busy,
    output logic                        err_flag,
    input  logic                        err_clr
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0]          TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [APB_ADDR_WIDTH-1:0] STRIDE   = APB_ADDR_WIDTH'(ADDR_STRIDE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        TXRESP = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [APB_ADDR_WIDTH-1:0] base_addr;
    logic [APB_ADDR_WIDTH-1:0] curr_addr;
    logic [15:0]               beat_cnt;
    logic [APB_DATA_WIDTH-1:0] wdata;
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      dir;        // 1 = write beat, 0 = read beat
    logic [TMO_W-1:0]          tmo_cnt;

    logic [15:0]               len_m1;
    logic                      block_last;
    logic [APB_ADDR_WIDTH-1:0] addr_inc;
    logic                      tmo_hit;
    logic                      beat_ok;
    logic                      beat_err;
    logic                      rd_start;

    // wrap_length of 0 behaves as a one-beat block.
    assign len_m1     = (wrap_length == 16'd0) ? 16'd0 : wrap_length - 16'd1;
    // ">=" rather than "==" so that a block length shortened between bursts
    // cannot let beat_cnt run past the end of the block.
    assign block_last = (beat_cnt >= len_m1);
    assign addr_inc   = curr_addr + STRIDE;   // modulo 2^APB_ADDR_WIDTH
    assign tmo_hit    = (tmo_cnt == TMO_LAST);
    assign beat_ok    = (state == ACCESS) && pready && !pslverr;
    assign beat_err   = (state == ACCESS) && (pready ? pslverr : tmo_hit);
    // A write word wins over a simultaneous read request.
    assign rd_start   = !rx_valid && start_tx && !cs;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values of its inputs.
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned, which
        // would otherwise infer a latch.
        state_next = state;
        unique case (state)
            IDLE: begin
                if (rx_valid || rd_start) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (beat_ok) begin
                    state_next = dir ? IDLE : TXRESP;
                end else if (beat_err) begin
                    state_next = IDLE;
                end
            end
            TXRESP: begin
                // beat_cnt already points past the delivered beat; zero means
                // the block is complete.
                if (tx_ready) begin
                    state_next = ((beat_cnt == 16'd0) || cs) ? IDLE : SETUP;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        psel     = 1'b0;
        penable  = 1'b0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        busy     = 1'b1;
        unique case (state)
            IDLE: begin
                rx_ready = 1'b1;
                busy     = 1'b0;
            end
            SETUP: begin
                psel = 1'b1;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            TXRESP: begin
                tx_valid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
        pwrite = psel & dir;
        pstrb  = {(APB_DATA_WIDTH/8){pwrite}};
    end

    assign paddr   = curr_addr;
    assign pwdata  = wdata;
    assign tx_data = rdata;

    // ------------------------------------------------------------------
    // Datapath: addresses, beat counter, data registers, timeout, error flag
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            base_addr <= '0;
            curr_addr <= '0;
            beat_cnt  <= '0;
            wdata     <= '0;
            rdata     <= '0;
            dir       <= 1'b0;
            tmo_cnt   <= '0;
            err_flag  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rxtx_addr_valid) begin
                        base_addr <= rxtx_addr;
                        curr_addr <= rxtx_addr;
                        beat_cnt  <= '0;
                    end
                    if (rx_valid) begin
                        wdata <= rx_data;
                        dir   <= 1'b1;
                    end else if (rd_start) begin
                        dir       <= 1'b0;
                        beat_cnt  <= '0;
                        // A base loaded in the same cycle is the base to use.
                        curr_addr <= rxtx_addr_valid ? rxtx_addr : base_addr;
                    end
                end
                SETUP: begin
                    tmo_cnt <= '0;
                end
                ACCESS: begin
                    if (!pready) begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                    if (beat_ok) begin
                        if (block_last) begin
                            beat_cnt <= '0;
                            if (wrap_en) begin
                                curr_addr <= base_addr;
                            end else begin
                                curr_addr <= addr_inc;
                                base_addr <= addr_inc;
                            end
                        end else begin
                            beat_cnt  <= beat_cnt + 16'd1;
                            curr_addr <= addr_inc;
                        end
                        if (!dir) begin
                            rdata <= prdata;
                        end
                    end else if (beat_err) begin
                        beat_cnt  <= '0;
                        curr_addr <= base_addr;
                    end
                end
                default: begin
                end
            endcase

            // Setting wins over a simultaneous clear.
            if (beat_err) begin
                err_flag <= 1'b1;
            end else if (err_clr) begin
                err_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_apb_burst_plug.sv
// -----------------------------------------------------------------------------
// Testbench for spi_slave_apb_burst_plug.
// Stimulus tasks push expected APB beats and transmit words into queues; an
// APB slave process answers each beat from a per-beat plan (wait states,
// PSLVERR, read data); a separate monitor pops and compares whenever the DUT
// starts an APB beat or hands over a transmit word.
// Reference addressing: k counts completed beats since the last base load;
// address = base + STRIDE*(k mod len) when wrapping, base + STRIDE*k when
// linear; a new read burst or an error rewinds k to the start of its block.
// -----------------------------------------------------------------------------
module tb_spi_slave_apb_burst_plug;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int STRIDE = 4;
    localparam int TMO    = 4;

    logic            pclk = 1'b0;
    logic            presetn;
    logic            psel, penable, pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic [DW/8-1:0] pstrb;
    logic [DW-1:0]   prdata;
    logic            pready, pslverr;
    logic [AW-1:0]   rxtx_addr;
    logic            rxtx_addr_valid, start_tx, cs;
    logic [DW-1:0]   rx_data;
    logic            rx_valid, rx_ready;
    logic [DW-1:0]   tx_data;
    logic            tx_valid, tx_ready;
    logic [15:0]     wrap_length;
    logic            wrap_en, busy, err_flag, err_clr;

    logic rand_ready, ready_dir, rnd_ready;
    assign tx_ready = rand_ready ? rnd_ready : ready_dir;

    always #5 pclk = ~pclk;

    spi_slave_apb_burst_plug #(
        .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW),
        .ADDR_STRIDE(STRIDE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .pclk(pclk), .presetn(presetn),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .rxtx_addr(rxtx_addr), .rxtx_addr_valid(rxtx_addr_valid),
        .start_tx(start_tx), .cs(cs),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wrap_length(wrap_length), .wrap_en(wrap_en),
        .busy(busy), .err_flag(err_flag), .err_clr(err_clr)
    );

    typedef struct {
        int unsigned   waits;
        bit            err;
        logic [DW-1:0] rdata;
    } plan_t;

    typedef struct {
        logic [AW-1:0] addr;
        bit            write;
        logic [DW-1:0] wdata;
    } apb_exp_t;

    plan_t         plan_q[$];
    plan_t         dir_q[$];
    apb_exp_t      apb_q[$];
    logic [DW-1:0] tx_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [AW-1:0] m_base = '0;
    int unsigned   m_k    = 0;
    int unsigned   m_len  = 1;
    bit            m_wrap = 1'b0;
    bit            m_err  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] model_addr();
        if (m_wrap) return m_base + AW'(STRIDE * (m_k % m_len));
        return m_base + AW'(STRIDE * m_k);
    endfunction

    function automatic bit fails(input plan_t p);
        return p.err || (p.waits >= TMO);
    endfunction

    function automatic int acc_cycles(input plan_t p);
        return (p.waits >= TMO) ? TMO : int'(p.waits) + 1;
    endfunction

    function automatic plan_t rand_plan();
        plan_t p;
        p.waits = $urandom_range(0, 3);
        p.err   = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 19) == 0) p.waits = TMO + 2;
        p.rdata = $urandom;
        return p;
    endfunction

    function automatic plan_t next_plan();
        if (dir_q.size() != 0) return dir_q.pop_front();
        return rand_plan();
    endfunction

    // ------------------------------------------------------------------
    // APB slave: answers each ACCESS phase from the next plan entry
    // ------------------------------------------------------------------
    plan_t       slv_p;
    logic        slv_active = 1'b0;
    int unsigned slv_wait;

    always @(posedge pclk) begin
        #2;
        if (presetn && psel && penable) begin
            if (!slv_active) begin
                slv_active = 1'b1;
                if (plan_q.size() != 0) slv_p = plan_q.pop_front();
                else slv_p = '{0, 1'b0, '0};
                slv_wait = slv_p.waits;
            end
            if (slv_wait > 0) begin
                pready  = 1'b0;
                pslverr = 1'b0;
                prdata  = $urandom;
                slv_wait--;
            end else begin
                pready  = 1'b1;
                pslverr = slv_p.err;
                prdata  = slv_p.rdata;
            end
        end else begin
            slv_active = 1'b0;
            pready     = 1'b0;
            pslverr    = 1'b0;
        end
    end

    always @(posedge pclk) begin
        #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    apb_exp_t      mon_e;
    logic [DW-1:0] mon_t;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data;

    always @(negedge pclk) begin
        if (!presetn) begin
            prev_hold = 1'b0;
        end else begin
            if (psel && !penable) begin
                check("apb beat expected", apb_q.size() != 0, 1);
                if (apb_q.size() != 0) begin
                    mon_e = apb_q.pop_front();
                    check("paddr", paddr, mon_e.addr);
                    check("pwrite", pwrite, mon_e.write);
                    check("pstrb", pstrb, mon_e.write ? 4'hF : 4'h0);
                    if (mon_e.write) check("pwdata", pwdata, mon_e.wdata);
                end
            end
            if (prev_hold) check("tx held stable", {tx_valid, tx_data}, {1'b1, prev_data});
            if (tx_valid && tx_ready) begin
                check("tx word expected", tx_q.size() != 0, 1);
                if (tx_q.size() != 0) begin
                    mon_t = tx_q.pop_front();
                    check("tx_data", tx_data, mon_t);
                end
            end
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge pclk);
        while (busy && n < 200) begin
            @(negedge pclk);
            n++;
        end
        check({name, " returns idle"}, busy, 0);
    endtask

    task automatic set_base(input logic [AW-1:0] a, input logic [15:0] wl, input bit we);
        wrap_length     = wl;
        wrap_en         = we;
        rxtx_addr       = a;
        rxtx_addr_valid = 1'b1;
        tick();
        rxtx_addr_valid = 1'b0;
        m_base = a;
        m_k    = 0;
        m_len  = (wl == 16'd0) ? 1 : int'(wl);
        m_wrap = we;
    endtask

    task automatic do_write(input logic [DW-1:0] d, input plan_t p);
        int n = 0;
        apb_q.push_back('{model_addr(), 1'b1, d});
        plan_q.push_back(p);
        if (fails(p)) begin
            m_err = 1'b1;
            m_k   = m_k - (m_k % m_len);
        end else begin
            m_k++;
        end
        rx_data  = d;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        do begin
            @(negedge pclk);
            n++;
        end while (!rx_ready && n < 100);
        check("write turnaround cycles", n, 2 + acc_cycles(p));
    endtask

    task automatic do_read(input string name);
        plan_t p;
        plan_t first;
        int    nb = 0;
        int    n  = 0;
        m_k = m_k - (m_k % m_len);
        do begin
            p = next_plan();
            if (nb == 0) first = p;
            nb++;
            apb_q.push_back('{model_addr(), 1'b0, '0});
            plan_q.push_back(p);
            if (fails(p)) begin
                m_err = 1'b1;
                m_k   = m_k - (m_k % m_len);
                break;
            end
            tx_q.push_back(p.rdata);
            m_k++;
        end while ((m_k % m_len) != 0);
        cs       = 1'b0;
        start_tx = 1'b1;
        tick();
        start_tx = 1'b0;
        do begin
            @(negedge pclk);
            n++;
        end while (!tx_valid && busy && n < 100);
        check({name, " first-beat latency"}, n, 2 + acc_cycles(first));
        wait_idle(name);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_err   = 1'b0;
        @(negedge pclk);
        check("err_flag cleared", err_flag, 0);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int n;
        presetn = 1'b0;
        rxtx_addr = '0; rxtx_addr_valid = 1'b0; start_tx = 1'b0; cs = 1'b1;
        rx_data = '0; rx_valid = 1'b0; wrap_length = 16'd1; wrap_en = 1'b0;
        err_clr = 1'b0; rand_ready = 1'b0; ready_dir = 1'b1;

        // Reset values
        #12;
        check("reset ctrl", {psel, penable, pwrite, pstrb, busy, err_flag, tx_valid}, 0);
        check("reset paddr", paddr, 0);
        check("reset pwdata", pwdata, 0);
        check("reset tx_data", tx_data, 0);
        check("reset rx_ready", rx_ready, 1);
        @(negedge pclk);
        presetn = 1'b1;
        tick();

        // Wrapping write burst: 0x100, 0x104, 0x108, then back to 0x100
        set_base(32'h100, 16'd3, 1'b1);
        for (int i = 0; i < 4; i++) do_write(32'hC0DE_0000 + 32'(i), '{0, 1'b0, '0});

        // Linear read burst of two beats, then a repeated start continues at 0x208
        set_base(32'h200, 16'd2, 1'b0);
        dir_q.push_back('{0, 1'b0, 32'hA});
        dir_q.push_back('{0, 1'b0, 32'hB});
        do_read("linear read 1");
        dir_q.push_back('{0, 1'b0, 32'hC});
        dir_q.push_back('{0, 1'b0, 32'hD});
        do_read("linear read 2");

        // Three wait states on a read
        set_base(32'h300, 16'd1, 1'b1);
        dir_q.push_back('{3, 1'b0, 32'hDEAD_BEEF});
        do_read("wait-state read");
        check("no error after wait states", err_flag, 0);

        // PSLVERR on the second beat of a four-beat wrap read
        set_base(32'h700, 16'd4, 1'b1);
        dir_q.push_back('{0, 1'b0, 32'h1111_0001});
        dir_q.push_back('{1, 1'b1, 32'h1111_0002});
        do_read("pslverr read");
        check("err_flag after pslverr", err_flag, 1);
        for (int i = 0; i < 4; i++) dir_q.push_back('{0, 1'b0, 32'h2222_0000 + 32'(i)});
        do_read("read after error restarts at base");
        pulse_clr();

        // PREADY stuck low: abort after TMO access cycles; set beats held clear
        set_base(32'h600, 16'd1, 1'b1);
        err_clr = 1'b1;
        do_write(32'h5555_AAAA, '{100, 1'b0, '0});
        err_clr = 1'b0;
        m_err   = 1'b1;
        check("err_flag after timeout", err_flag, 1);
        check("psel dropped after timeout", {psel, busy}, 0);
        pulse_clr();

        // wrap_length 0 behaves as one beat: the same address twice
        set_base(32'h500, 16'd0, 1'b1);
        do_read("length-0 read 1");
        do_read("length-0 read 2");

        // cs rises while a word waits in TXRESP: word delivered, burst ends
        set_base(32'h400, 16'd4, 1'b1);
        ready_dir = 1'b0;
        apb_q.push_back('{32'h400, 1'b0, '0});
        plan_q.push_back('{0, 1'b0, 32'h0BAD_CAFE});
        tx_q.push_back(32'h0BAD_CAFE);
        m_k = 1;
        cs = 1'b0; start_tx = 1'b1; tick(); start_tx = 1'b0;
        n = 0;
        do begin
            @(negedge pclk);
            n++;
        end while (!tx_valid && n < 50);
        check("tx_valid before cs rise", tx_valid, 1);
        tick(); tick();
        cs = 1'b1;
        tick();
        ready_dir = 1'b1;
        wait_idle("cs rise");
        check("no further beats after cs rise", apb_q.size() + plan_q.size() + tx_q.size(), 0);
        cs = 1'b0;

        // Asynchronous reset in the middle of ACCESS
        set_base(32'h800, 16'd1, 1'b1);
        apb_q.push_back('{32'h800, 1'b0, '0});
        plan_q.push_back('{2, 1'b0, 32'h1234_5678});
        start_tx = 1'b1; tick(); start_tx = 1'b0;
        n = 0;
        do begin
            @(negedge pclk);
            n++;
        end while (!(psel && penable) && n < 20);
        check("reached ACCESS", psel && penable, 1);
        #1 presetn = 1'b0;
        #1;
        check("async reset ctrl", {psel, penable, pwrite, pstrb, busy, err_flag, tx_valid}, 0);
        check("async reset paddr", paddr, 0);
        check("async reset tx_data", tx_data, 0);
        check("async reset rx_ready", rx_ready, 1);
        plan_q.delete(); apb_q.delete(); tx_q.delete();
        m_base = '0; m_k = 0; m_err = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        tick();

        // Randomised traffic, including address wrap-around at 2^32
        rand_ready = 1'b1;
        set_base(32'hFFFF_FFF8, 16'd3, 1'b0);
        for (int i = 0; i < 60; i++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op == 0) begin
                set_base(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC),
                         16'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
            end else if (op == 1) begin
                pulse_clr();
            end else if (op <= 5) begin
                do_write($urandom, rand_plan());
            end else begin
                do_read("random read");
            end
            @(negedge pclk);
            check("err_flag matches model", err_flag, m_err);
        end

        rand_ready = 1'b0;
        repeat (3) tick();
        check("apb queue drained", apb_q.size(), 0);
        check("tx queue drained", tx_q.size(), 0);
        check("plan queue drained", plan_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
